// File: rtl/atm_pager_rdbk.sv
// rtl/atm_pager_rdbk.sv - shadow and index/data readback of the four ATM pager windows
//
// Keeps a copy of each window's page, ram/rom and 7ffd-mode bits for both maps by
// snooping the xxF7 write strobe, and returns that state one byte at a time.
//
// Ports:
//   fclk        system clock, all state on its rising edge
//   rst_n       asynchronous active-low reset
//   za[15:0]    Z80 address; [15:14] window, [11] port flavour (1 = xFF7, 0 = x7F7)
//   zd[7:0]     Z80 data
//   pent1m_ROM  map select, same as the pagers see
//   atmF7_wr    xxF7 write strobe, one fclk wide
//   idx_wr      index-port write strobe, one fclk wide
//   rd_stb      data-port read strobe, one fclk wide
//   rd_data     registered readback byte, held until the next rd_stb
//   idx         current readback index

module atm_pager_rdbk (
   input  logic        fclk,
   input  logic        rst_n,
   input  logic [15:0] za,
   input  logic [7:0]  zd,
   input  logic        pent1m_ROM,
   input  logic        atmF7_wr,
   input  logic        idx_wr,
   input  logic        rd_stb,
   output logic [7:0]  rd_data,
   output logic [3:0]  idx
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   // Entry layout: {d7, rn, pg[7:0]}, addressed as {window, map}.
   logic [9:0] r_shadow [8];
   logic [3:0] r_idx;
   logic [7:0] r_rd_data;
   logic [0:0] r_state;

   logic [2:0] w_wsel;
   logic [9:0] w_wentry;
   logic [9:0] w_rentry;
   logic [7:0] w_rbyte;
   logic       w_unused;

   // Reset image mirrors the pagers' pent1m-mode defaults.
   function automatic logic [9:0] reset_entry(input int e);
      logic [9:0] v;
      case (e)
         0:       v = {1'b1, 1'b0, 8'h01};
         1:       v = {1'b1, 1'b0, 8'h03};
         2, 3:    v = {1'b0, 1'b1, 8'hFA};
         4, 5:    v = {1'b0, 1'b1, 8'hFD};
         default: v = {1'b1, 1'b1, 8'hFF};
      endcase
      return v;
   endfunction

   assign w_wsel = {za[15:14], pent1m_ROM};

   // xFF7 carries a 6-bit page plus both flags; x7F7 carries a full page,
   // forces RAM and leaves the 7ffd-mode bit as it was.
   always_comb begin
      w_wentry = '0;
      if (za[11]) begin
         w_wentry = {zd[7], zd[6], 2'b00, zd[5:0]};
      end else begin
         w_wentry = {r_shadow[w_wsel][9], 1'b1, zd};
      end
   end

   assign w_rentry = r_shadow[r_idx[3:1]];
   assign w_rbyte  = r_idx[0] ? {w_rentry[9], w_rentry[8], 6'b000000} : w_rentry[7:0];

   assign w_unused = ^{za[13:12], za[10:0]};

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < 8; e++) begin
            r_shadow[e] <= reset_entry(e);
         end
      end else if (atmF7_wr) begin
         r_shadow[w_wsel] <= w_wentry;
      end
   end

   // A read samples the pre-write shadow, so a same-cycle atmF7_wr is not seen.
   // A same-cycle idx_wr overrides the post-read increment.
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx     <= 4'd0;
         r_rd_data <= 8'h00;
      end else begin
         if (rd_stb) begin
            r_rd_data <= w_rbyte;
         end
         if (idx_wr) begin
            r_idx <= zd[3:0];
         end else if (rd_stb) begin
            r_idx <= r_idx + 4'd1;
         end
      end
   end

   // HOLD marks that rd_data has been latched and is frozen until the next
   // strobe; it is a debug indicator only and never gates data.
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (rd_stb) r_state <= ST_HOLD;
            ST_HOLD: if (idx_wr) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rd_data = r_rd_data;
   assign idx     = r_idx;

endmodule

// File: tb/tb_atm_pager_rdbk.sv
// tb/tb_atm_pager_rdbk.sv - scoreboard bench for atm_pager_rdbk

module tb_atm_pager_rdbk;

   logic        fclk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] za = 16'h0000;
   logic [7:0]  zd = 8'h00;
   logic        pent1m_ROM = 1'b0;
   logic        atmF7_wr = 1'b0;
   logic        idx_wr = 1'b0;
   logic        rd_stb = 1'b0;
   logic [7:0]  rd_data;
   logic [3:0]  idx;

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q [$];

   atm_pager_rdbk dut (
      .fclk       (fclk),
      .rst_n      (rst_n),
      .za         (za),
      .zd         (zd),
      .pent1m_ROM (pent1m_ROM),
      .atmF7_wr   (atmF7_wr),
      .idx_wr     (idx_wr),
      .rd_stb     (rd_stb),
      .rd_data    (rd_data),
      .idx        (idx)
   );

   always #5 fclk = ~fclk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // Monitor: every accepted read strobe produces one byte, compared one cycle later.
   initial begin
      logic [7:0] e;
      forever begin
         @(posedge fclk);
         if (rst_n && rd_stb) begin
            #1;
            if (exp_q.size() == 0) begin
               chk("unexpected_read", rd_data, 8'hxx);
            end else begin
               e = exp_q.pop_front();
               chk("rd_data", rd_data, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   task automatic idx_write(input logic [3:0] v);
      @(negedge fclk);
      zd = {4'hA, v};
      idx_wr = 1'b1;
      @(negedge fclk);
      idx_wr = 1'b0;
   endtask

   task automatic rd(input logic [7:0] exp);
      @(negedge fclk);
      rd_stb = 1'b1;
      exp_q.push_back(exp);
      @(negedge fclk);
      rd_stb = 1'b0;
   endtask

   task automatic f7(input logic [15:0] a, input logic rom, input logic [7:0] d);
      @(negedge fclk);
      za = a;
      pent1m_ROM = rom;
      zd = d;
      atmF7_wr = 1'b1;
      @(negedge fclk);
      atmF7_wr = 1'b0;
   endtask

   task automatic reset_dump();
      logic [7:0] tbl [16];
      tbl = '{8'h01, 8'h80, 8'h03, 8'h80, 8'hFA, 8'h40, 8'hFA, 8'h40,
              8'hFD, 8'h40, 8'hFD, 8'h40, 8'hFF, 8'hC0, 8'hFF, 8'hC0};
      idx_write(4'd0);
      for (int i = 0; i < 16; i++) rd(tbl[i]);
      chk("dump_idx_wrap", {4'h0, idx}, 8'h00);
   endtask

   initial begin
      logic [7:0] pre7 [7];
      pre7 = '{8'h01, 8'h80, 8'h00, 8'h00, 8'hFA, 8'h40, 8'h05};

      #1;
      chk("reset_rd_data", rd_data, 8'h00);
      chk("reset_idx", {4'h0, idx}, 8'h00);
      repeat (3) @(negedge fclk);
      rst_n = 1'b1;

      reset_dump();

      // xFF7 to window 1, map 1
      f7(16'h7FF7, 1'b1, 8'hC5);
      idx_write(4'd6);
      rd(8'h05);
      rd(8'hC0);
      idx_write(4'd4);
      rd(8'hFA);

      // x7F7 to window 3, map 0 keeps d7
      f7(16'hF7F7, 1'b0, 8'h12);
      idx_write(4'd12);
      rd(8'h12);
      rd(8'hC0);

      // read and write to the same entry together
      idx_write(4'd2);
      @(negedge fclk);
      rd_stb = 1'b1; atmF7_wr = 1'b1; za = 16'h3FF7; pent1m_ROM = 1'b1; zd = 8'h00;
      exp_q.push_back(8'h03);
      @(negedge fclk);
      rd_stb = 1'b0; atmF7_wr = 1'b0;
      idx_write(4'd2);
      rd(8'h00);

      // read and index write together
      idx_write(4'd5);
      @(negedge fclk);
      rd_stb = 1'b1; idx_wr = 1'b1; zd = 8'h0E;
      exp_q.push_back(8'h40);
      @(negedge fclk);
      rd_stb = 1'b0; idx_wr = 1'b0;
      chk("collide_idx", {4'h0, idx}, 8'h0E);
      rd(8'hFF);
      chk("after_collide_idx", {4'h0, idx}, 8'h0F);

      // rewriting the entry just read must not disturb held rd_data
      f7(16'hFFF7, 1'b1, 8'h3F);
      chk("hold_frozen", rd_data, 8'hFF);

      // partial dump, then asynchronous reset between edges
      idx_write(4'd0);
      for (int i = 0; i < 7; i++) rd(pre7[i]);
      chk("pre_reset_idx", {4'h0, idx}, 8'h07);
      @(posedge fclk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_idx", {4'h0, idx}, 8'h00);
      chk("async_rst_rd_data", rd_data, 8'h00);
      // strobes during reset are ignored
      rd_stb = 1'b1; atmF7_wr = 1'b1; idx_wr = 1'b1; za = 16'h3FF7; zd = 8'h09;
      @(posedge fclk);
      #1;
      chk("rst_strobe_idx", {4'h0, idx}, 8'h00);
      chk("rst_strobe_rd_data", rd_data, 8'h00);
      @(negedge fclk);
      rd_stb = 1'b0; atmF7_wr = 1'b0; idx_wr = 1'b0;
      rst_n = 1'b1;

      reset_dump();

      repeat (2) @(negedge fclk);
      chk("queue_drained", 8'(exp_q.size()), 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
